// File: rtl/mul_seq_32_if.sv
// mul_seq_32_if -- request/response bundle for the sequential multiplier.
//   start  : request, sampled only while the multiplier is idle
//   op     : 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1    : operand A (multiplier)
//   rs2    : operand B (multiplicand)
//   busy   : operation in flight
//   done   : one-cycle pulse, result valid
//   result : selected product word, held until the next accepted start
// The master modport is the requester (execute stage); slave is the multiplier.
interface mul_seq_32_if #(
  parameter int N = 32
);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] rs1;
  logic [N-1:0] rs2;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  modport master (
    output start, op, rs1, rs2,
    input  busy, done, result
  );

  modport slave (
    input  start, op, rs1, rs2,
    output busy, done, result
  );
endinterface

// File: rtl/mul_seq_32.sv
// mul_seq_32 -- iterative radix-2 shift-and-add multiplier for RV32M
// MUL/MULH/MULHSU/MULHU.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset; abandons any operation in flight
//   mul : slave side of mul_seq_32_if (start/op/rs1/rs2 in,
//         busy/done/result out)
// Signed operands are converted to magnitudes, multiplied unsigned over N
// shift-add iterations, then the 2N-bit product is negated if the signs
// differed. Sequence per operation: accept, N x RUN, FIX, DONE; the result
// and done pulse are registered on the edge leaving DONE.
module mul_seq_32 #(
  parameter int N     = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  mul_seq_32_if.slave   mul
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [N-1:0]     ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0]   ONE_2N   = {{(2*N-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t           state_q;
  logic [1:0]       op_q;
  logic [N-1:0]     mcand_q;
  logic [N-1:0]     mplier_q;
  logic [N-1:0]     acc_q;
  logic             neg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [N-1:0]     result_q;

  logic             sign_a_d;
  logic             sign_b_d;
  logic [N-1:0]     mplier_d;
  logic [N-1:0]     mcand_d;
  logic [N-1:0]     addend_d;
  logic [N:0]       sum_d;
  logic [2*N-1:0]   prod_neg_d;

  always_comb begin
    sign_a_d   = 1'b0;
    sign_b_d   = 1'b0;
    mplier_d   = mul.rs1;
    mcand_d    = mul.rs2;
    addend_d   = '0;
    sum_d      = '0;
    prod_neg_d = '0;

    // rs1 is signed for MULH and MULHSU, rs2 only for MULH. MUL and MULHU
    // run unsigned: the low word does not depend on signedness.
    sign_a_d = ((mul.op == 2'b01) || (mul.op == 2'b10)) && mul.rs1[N-1];
    sign_b_d = (mul.op == 2'b01) && mul.rs2[N-1];
    // Most-negative value maps onto itself, which is the correct unsigned
    // magnitude 2^(N-1).
    if (sign_a_d) mplier_d = ~mul.rs1 + ONE_N;
    if (sign_b_d) mcand_d  = ~mul.rs2 + ONE_N;

    // N-bit adder; the carry-out is kept as bit N and shifted into the
    // top of the accumulator, so acc never needs a physical 33rd bit.
    addend_d = mplier_q[0] ? mcand_q : '0;
    sum_d    = {1'b0, acc_q} + {1'b0, addend_d};

    prod_neg_d = ~{acc_q, mplier_q} + ONE_2N;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (mul.start) begin
            op_q     <= mul.op;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= sign_a_d ^ sign_b_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          // {acc, mplier} <= {carry, sum, mplier} >> 1
          acc_q    <= sum_d[N:1];
          mplier_q <= {sum_d[0], mplier_q[N-1:1]};
          cnt_q    <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) state_q <= S_FIX;
        end
        S_FIX: begin
          if (neg_q) {acc_q, mplier_q} <= prod_neg_d;
          state_q <= S_DONE;
        end
        S_DONE: begin
          result_q <= (op_q == 2'b00) ? mplier_q : acc_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mul.busy   = busy_q;
  assign mul.done   = done_q;
  assign mul.result = result_q;

endmodule

// File: tb/tb_mul_seq_32.sv
// tb_mul_seq_32 -- self-checking bench for mul_seq_32. Expected products come
// from a 64-bit arithmetic reference (sign/zero extension then multiply) and
// from the directed constants of the test plan.
module tb_mul_seq_32;

  localparam int LAT     = 34;   // accept edge to done-visible edge
  localparam int MAX_LAT = 100;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mul_seq_32_if mif ();

  mul_seq_32 dut (
    .clk (clk),
    .rst (rst),
    .mul (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0000_0000;
      1:       v = 32'h0000_0001;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one request and wait (bounded) for done. Returns at #1 after the
  // edge on which done became visible; lat counts edges after the accept edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output logic [31:0] res);
    @(negedge clk);
    mif.start = 1'b1;
    mif.op    = op;
    mif.rs1   = a;
    mif.rs2   = b;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    mif.op    = 2'($urandom);
    mif.rs1   = $urandom;
    mif.rs2   = $urandom;
    lat = 0;
    res = 32'hDEAD_BEEF;
    while (lat < MAX_LAT) begin
      @(posedge clk);
      lat++;
      #1;
      if (mif.done) break;
    end
    if (mif.done) res = mif.result;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    mif.start = 1'b1;
    mif.op    = 2'b01;
    mif.rs1   = $urandom;
    mif.rs2   = $urandom;
    repeat (3) @(posedge clk);
    #1;
    mif.start = 1'b0;
    checks++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0 || mif.result !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b result=%h required 0/0/00000000",
               mif.busy, mif.done, mif.result);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mif.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b required 0", mif.busy);
    end
  endtask

  task automatic test_basic();
    int          lat;
    logic [31:0] res;
    run_op(2'b00, 32'd7, 32'd6, lat, res);
    $display("op=0 rs1=00000007 rs2=00000006 result=%h latency=%0d", res, lat);
    checks++;
    if (lat !== LAT) begin
      failures++;
      $display("FAIL basic_latency got=%0d required=%0d", lat, LAT);
    end
    checks++;
    if (res !== 32'h0000_002A) begin
      failures++;
      $display("FAIL basic_result got=%h required=0000002a", res);
    end
    checks++;
    if (mif.busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_in_done got=%b required=0", mif.busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mif.done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse got=%b required=0", mif.done);
    end
    checks++;
    if (mif.result !== 32'h0000_002A) begin
      failures++;
      $display("FAIL basic_result_hold got=%h required=0000002a", mif.result);
    end
  endtask

  task automatic test_corners();
    logic [1:0]  ops [9] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11,
                             2'b11, 2'b01};
    logic [31:0] as  [9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                             32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    logic [31:0] bs  [9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                             32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    logic [31:0] exp [9] = '{32'h0000_0001, 32'h0000_0000, 32'h4000_0000,
                             32'h4000_0000, 32'h0000_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    int          lat;
    logic [31:0] res;
    for (int i = 0; i < 9; i++) begin
      run_op(ops[i], as[i], bs[i], lat, res);
      $display("op=%0d rs1=%h rs2=%h result=%h latency=%0d",
               ops[i], as[i], bs[i], res, lat);
      checks++;
      if (res !== exp[i] || lat !== LAT) begin
        failures++;
        $display("FAIL corner_%0d result=%h latency=%0d required %h/%0d",
                 i, res, lat, exp[i], LAT);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    logic [31:0] res;
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom);
      a   = pick_operand();
      b   = ($urandom_range(0, 7) == 0) ? a : pick_operand();
      exp = model(op, a, b);
      run_op(op, a, b, lat, res);
      $display("op=%0d rs1=%h rs2=%h result=%h latency=%0d", op, a, b, res, lat);
      checks++;
      if (res !== exp || lat !== LAT) begin
        failures++;
        $display("FAIL random_%0d op=%0d rs1=%h rs2=%h result=%h latency=%0d required %h/%0d",
                 i, op, a, b, res, lat, exp, LAT);
      end
    end
  endtask

  // A start pulse mid-operation is dropped; a MUL issued in the done cycle
  // is accepted back-to-back.
  task automatic test_back_to_back();
    int          lat;
    logic [31:0] res;
    @(negedge clk);
    mif.start = 1'b1;
    mif.op    = 2'b11;
    mif.rs1   = 32'h1234_5678;
    mif.rs2   = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    lat = 0;
    while (lat < MAX_LAT) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 9) begin
        mif.start = 1'b1;
        mif.op    = 2'b00;
        mif.rs1   = 32'h0000_0011;
        mif.rs2   = 32'h0000_0022;
      end
      if (lat == 10) begin
        mif.start = 1'b0;
        checks++;
        if (mif.busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_busy_mid got=%b required=1", mif.busy);
        end
      end
      if (mif.done) break;
    end
    res = mif.result;
    $display("op=3 rs1=12345678 rs2=9abcdef0 result=%h latency=%0d", res, lat);
    checks++;
    if (res !== 32'h0B00_EA4E || lat !== LAT) begin
      failures++;
      $display("FAIL b2b_ignored_start result=%h latency=%0d required 0b00ea4e/%0d",
               res, lat, LAT);
    end
    // run_op raises start at the next negedge, i.e. inside the done cycle.
    run_op(2'b00, 32'd3, 32'd5, lat, res);
    $display("op=0 rs1=00000003 rs2=00000005 result=%h latency=%0d", res, lat);
    checks++;
    if (res !== 32'h0000_000F || lat !== LAT) begin
      failures++;
      $display("FAIL b2b_reissue result=%h latency=%0d required 0000000f/%0d",
               res, lat, LAT);
    end
  endtask

  task automatic test_reset_midop();
    int          lat;
    logic [31:0] res;
    bit          seen;
    @(negedge clk);
    mif.start = 1'b1;
    mif.op    = 2'b01;
    mif.rs1   = 32'hCAFE_0001;
    mif.rs2   = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0 || mif.result !== 32'h0) begin
      failures++;
      $display("FAIL midop_reset busy=%b done=%b result=%h required 0/0/00000000",
               mif.busy, mif.done, mif.result);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (mif.done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL midop_no_done got done=1 required none");
    end
    run_op(2'b00, 32'd2, 32'd3, lat, res);
    $display("op=0 rs1=00000002 rs2=00000003 result=%h latency=%0d", res, lat);
    checks++;
    if (res !== 32'h0000_0006 || lat !== LAT) begin
      failures++;
      $display("FAIL midop_recover result=%h latency=%0d required 00000006/%0d",
               res, lat, LAT);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    mif.start = 1'b0;
    mif.op    = 2'b00;
    mif.rs1   = '0;
    mif.rs2   = '0;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_seq_32.md
Name: mul_seq_32

Overview:
- Iterative radix-2 shift-and-add integer multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions.
- Sits beside the ALU in the execute stage and stalls the pipeline through busy/done.
- Each RUN cycle drives the 32-bit ripple adder datapath with the partial-product high word and the multiplicand, then consumes the sum.
- Adder carry-out is reconstructed locally as a 33rd bit.

Parameters:
- N, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > N.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MUL (low word), 01 MULH (s×s high), 10 MULHSU (rs1 signed × rs2 unsigned, high), 11 MULHU (u×u high).
- rs1  input  N  multiplier operand A.
- rs2  input  N  multiplier operand B.
- busy  output  1  high from the cycle after start is accepted until done is asserted.
- done  output  1  one-cycle pulse; result valid.
- result  output  N  product word selected by op; held until the next accepted start.

Behaviour:
- Reset: synchronous and active-high; takes effect at the next clk edge regardless of state, including mid-operation. Outputs after reset: busy=0, done=0, result=0, state=IDLE. All internal registers are cleared and any operation in progress is abandoned with no done pulse.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - If start=1 at an edge: latch op.
  - sign_a = rs1[31] when op∈{01,10}, else 0. sign_b = rs2[31] when op=01, else 0.
  - mcand = |rs2| if sign_b, else rs2. mplier = |rs1| if sign_a, else rs1. Magnitudes are N-bit unsigned; 0x80000000 maps to 0x80000000.
  - neg = sign_a XOR sign_b. acc = 0 (33 bits). cnt = 0. Go to RUN; busy=1.
- RUN, each edge:
  - sum = acc[31:0] + (mplier[0] ? mcand : 0), kept as a 33-bit result including carry.
  - {acc, mplier} ← {sum, mplier} >> 1, a logical 65→64-bit shift with the carry entering at the top.
  - cnt++. When cnt reaches N−1 on this edge, go to FIX. RUN therefore lasts exactly N edges.
- FIX: P = {acc[31:0], mplier}. If neg, P ← two's complement of P (64-bit). Go to DONE.
- DONE:
  - result ← P[31:0] when op=00, else P[63:32].
  - done=1 for this one cycle; busy=0.
  - Next edge returns to IDLE; done drops.
- Latency: start sampled at edge E0 → done high during the cycle following edge E0+34 (N+2 edges). Throughput is one operation per 35 cycles.
- start while busy or in DONE: ignored, with no queuing. Operands must be held only at the accept edge.
- start in the IDLE cycle immediately after DONE: accepted normally, giving back-to-back operation.
- Operands of 0 or 1, and rs1=rs2: no special-casing; the full N iterations always run.
- All arithmetic is modulo 2^64 on P. MUL ignores signs, since the low word is sign-independent. neg is forced to 0 for op=00 and op=11.

Test Plan:
- Reset, then MUL rs1=7, rs2=6 → done exactly 34 cycles after the accept edge, result=0x0000002A, busy low in the done cycle.
- MUL and MULH with rs1=rs2=0xFFFFFFFF → MUL result=0x00000001; MULH result=0x00000000.
- MULH rs1=rs2=0x80000000 → result=0x40000000. MULHU with the same operands → 0x40000000. MUL → 0x00000000.
- MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → result=0xFFFFFFFF. MULHU with the same operands → 0xFFFFFFFE.
- Start MULHU 0x12345678×0x9ABCDEF0 and pulse start with different operands at cycle 10 → second start ignored, result=0x0B00EA4E. Immediately re-issue MUL 3×5 in the next IDLE cycle → 0x0000000F.
- Assert rst at RUN cycle 15 → next edge: busy=0, result=0, no done pulse. A new MUL 2×3 then completes with 0x00000006 and nominal latency.
